regfile_bist: RTL

- Built-in self-test initiator for the 32x32 register bank. It drives the bank's write port (wr, wrData, wr_en) and both read ports (sr1/sr2 -> rdData1/rdData2).
- Runs a fixed multi-pattern write/read-back sequence and reports pass/fail with first-failure diagnostics.
- Sits beside the register bank. A mux outside this block selects BIST versus datapath access.

---
 rtl/regfile_bist_pkg.sv | 17 +
 rtl/regfile_bist.sv | 131 +++++++++++++
 2 files changed

// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg: FSM states, test patterns and pattern lookup for regfile_bist.
// REGFILE_BIST_ADDR_PATTERN_EN adds pattern 4 (data = address) to catch decode aliasing.
package regfile_bist_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
  localparam logic [31:0] PAT0 = 32'h0000_0000;
  localparam logic [31:0] PAT1 = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT2 = 32'hAAAA_AAAA;
  localparam logic [31:0] PAT3 = 32'h5555_5555;
`ifdef REGFILE_BIST_ADDR_PATTERN_EN
  localparam int NUM_PATS = 5;
`else
  localparam int NUM_PATS = 4;
`endif
  function automatic logic [31:0] pat_data(input logic [2:0] idx, input logic [31:0] addr);
    return idx == 3'd0 ? PAT0 : idx == 3'd1 ? PAT1 : idx == 3'd2 ? PAT2 : idx == 3'd3 ? PAT3 : addr;
  endfunction
endpackage

// File: rtl/regfile_bist.sv
// regfile_bist: write/read-back self-test of a register bank with first-failure capture.
// REGFILE_BIST_ADDR_PATTERN_EN (in regfile_bist_pkg) enables the address-as-data pattern.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_pat,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] wrData,
  output logic              wr_en,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2
);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_REGS - 1);
  localparam logic [2:0]        LAST_PAT = 3'(NUM_PATS - 1);
  state_e            state_q, state_d;
  logic [2:0]        pat_q, pat_d, fail_pat_q, fail_pat_d;
  logic [ADDR_W-1:0] wr_q, wr_d, sr1_q, sr1_d, sr2_q, sr2_d, fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, fail_data_q, fail_data_d, exp1, exp2;
  logic              wr_en_q, wr_en_d, pass_q, pass_d, mis1, mis2;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      wr_q        <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      sr1_q       <= '0;
      sr2_q       <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      wr_q        <= wr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      sr1_q       <= sr1_d;
      sr2_q       <= sr2_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_pat_q  <= fail_pat_d;
      fail_data_q <= fail_data_d;
    end

  assign exp1 = DATA_W'(pat_data(pat_q, 32'(sr1_q)));
  assign exp2 = DATA_W'(pat_data(pat_q, 32'(sr2_q)));
  assign mis1 = rdData1 != exp1;
  assign mis2 = rdData2 != exp2;

  // Bank-side outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    wr_en_d     = 1'b0;
    wr_d        = '0;
    wr_data_d   = '0;
    sr1_d       = '0;
    sr2_d       = '0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_pat_d  = fail_pat_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = WRITE;
        pat_d       = '0;
        wr_en_d     = 1'b1;
        wr_data_d   = DATA_W'(pat_data(3'd0, 32'd0));
        pass_d      = 1'b0;
        fail_addr_d = '0;
        fail_pat_d  = '0;
        fail_data_d = '0;
      end
      WRITE: if (wr_q == LAST) begin
        state_d = READ;
        sr2_d   = ADDR_W'(1);
      end else begin
        wr_en_d   = 1'b1;
        wr_d      = wr_q + ADDR_W'(1);
        wr_data_d = DATA_W'(pat_data(pat_q, 32'(wr_d)));
      end
      READ: if (mis1 || mis2) begin
        state_d     = DONE;
        fail_addr_d = mis1 ? sr1_q : sr2_q;
        fail_data_d = mis1 ? rdData1 : rdData2;
        fail_pat_d  = pat_q;
      end else if (sr2_q != LAST) begin
        sr1_d = sr1_q + ADDR_W'(2);
        sr2_d = sr2_q + ADDR_W'(2);
      end else if (pat_q == LAST_PAT) begin
        state_d = DONE;
        pass_d  = 1'b1;
      end else begin
        state_d   = WRITE;
        pat_d     = pat_q + 3'd1;
        wr_en_d   = 1'b1;
        wr_data_d = DATA_W'(pat_data(pat_d, 32'd0));
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = state_q == WRITE || state_q == READ;
  assign done      = state_q == DONE;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_pat  = fail_pat_q;
  assign fail_data = fail_data_q;
  assign wr        = wr_q;
  assign wrData    = wr_data_q;
  assign wr_en     = wr_en_q;
  assign sr1       = sr1_q;
  assign sr2       = sr2_q;
endmodule
